// File: rtl/axi_lite_sram_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and the byte-merge helper
// used by the SRAM responder.
package axi_lite_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_sram_lfsr_delay.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) advancing every cycle; low nibble feeds
// the read and write channel latency draws.
module lfsr_delay #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [1:0] o_rd_delay,
    output logic [1:0] o_wr_delay
);

    logic [7:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign o_rd_delay = r_lfsr[1:0];
    assign o_wr_delay = r_lfsr[3:2];

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite SRAM responder with independent read/write channel FSMs, one outstanding
// transaction per channel, and LFSR-driven random access latency.
module axi_lite_sram
    import axi_lite_sram_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h8000_0000,
    parameter logic [7:0]               LFSR_SEED  = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int unsigned           DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);

    logic [1:0] w_rd_delay;
    logic [1:0] w_wr_delay;

    lfsr_delay #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .o_rd_delay (w_rd_delay),
        .o_wr_delay (w_wr_delay)
    );

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    rd_state_t              r_rd_state;
    logic [1:0]             r_rd_cnt;
    logic [DEPTH_LOG2-1:0]  r_ar_idx;
    logic                   r_ar_ok;

    wr_state_t              r_wr_state;
    logic [1:0]             r_wr_cnt;
    logic                   r_aw_got;
    logic                   r_w_got;
    logic [DEPTH_LOG2-1:0]  r_aw_idx;
    logic                   r_aw_ok;
    logic [DATA_WIDTH-1:0]  r_w_data;
    logic [DATA_WIDTH/8-1:0] r_w_strb;

    logic [ADDR_WIDTH-1:0]  w_ar_off;
    logic [ADDR_WIDTH-1:0]  w_aw_off;
    logic                   w_ar_hs;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [DATA_WIDTH-1:0]  w_rd_word;

    assign w_ar_off = araddr - BASE_ADDR;
    assign w_aw_off = awaddr - BASE_ADDR;

    assign arready = (r_rd_state == R_IDLE);
    assign awready = (r_wr_state == W_IDLE) && !r_aw_got;
    assign wready  = (r_wr_state == W_IDLE) && !r_w_got;

    assign w_ar_hs = arvalid && arready;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    assign w_commit = (r_wr_state == W_WAIT) && (r_wr_cnt == 2'd0) && r_aw_ok;

    // A write committing this cycle to the word being captured is forwarded into rdata.
    assign w_rd_word = (w_commit && (r_aw_idx == r_ar_idx))
                     ? apply_strb(r_mem[r_ar_idx], r_w_data, r_w_strb)
                     : r_mem[r_ar_idx];

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_aw_idx] <= apply_strb(r_mem[r_aw_idx], r_w_data, r_w_strb);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= '0;
            r_ar_idx   <= '0;
            r_ar_ok    <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_idx   <= DEPTH_LOG2'(w_ar_off >> 2);
                        r_ar_ok    <= (w_ar_off < SPAN);
                        r_rd_cnt   <= w_rd_delay;
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rd_cnt != 2'd0) begin
                        r_rd_cnt <= r_rd_cnt - 2'd1;
                    end else begin
                        rdata      <= r_ar_ok ? w_rd_word : '0;
                        rresp      <= r_ar_ok ? RESP_OKAY : RESP_DECERR;
                        rvalid     <= 1'b1;
                        r_rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid     <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= '0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_aw_idx   <= '0;
            r_aw_ok    <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_aw_idx <= DEPTH_LOG2'(w_aw_off >> 2);
                        r_aw_ok  <= (w_aw_off < SPAN);
                    end
                    if (w_w_hs) begin
                        r_w_got  <= 1'b1;
                        r_w_data <= wdata;
                        r_w_strb <= wstrb;
                    end
                    if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
                        r_wr_cnt   <= w_wr_delay;
                        r_wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (r_wr_cnt != 2'd0) begin
                        r_wr_cnt <= r_wr_cnt - 2'd1;
                    end else begin
                        bresp      <= r_aw_ok ? RESP_OKAY : RESP_DECERR;
                        bvalid     <= 1'b1;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid     <= 1'b0;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
